// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: one registered adder time-shared between NREQ requesters.
// A round-robin pointer picks the next requester, and a three-state sequencer runs
// accept -> compute -> respond, so at most one operand pair is in flight.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for any req_valid; grants one requester and captures its pair
//   EXEC  | adds the captured operands into rsp_sum and raises rsp_valid
//   RESP  | holds the result until rsp_ready, then advances the pointer
module shared_adder_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 6,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [W:0]          rsp_sum,
    input  logic                rsp_ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   scan_idx;

    // Round-robin search: first valid requester starting at ptr and wrapping at NREQ.
    // The extra index bit keeps ptr+i from overflowing before the wrap subtraction.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(i);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    // One-hot accept strobe, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, addition, response hold and pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        a_q  <= req_a[int'(grant_id)*W +: W];
                        b_q  <= req_b[int'(grant_id)*W +: W];
                        id_q <= grant_id;
                    end
                end
                EXEC: begin
                    rsp_sum   <= {1'b0, a_q} + {1'b0, b_q};
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr_q     <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule
